fib_ctrl: RTL and testbench

Control unit for the 20-bit Fibonacci datapath `calc`. It accepts a request for term F(n) over a start/ready handshake and sequences the datapath's `rst_ctl`, `en` and `mux` inputs. It captures the datapath's `result` into an output register and reports completion with a one-cycle `done` pulse. It sits between the requesting logic and `calc`, and both are instanced side by side in the Fibonacci top level.

---
 rtl/fib_pkg.sv | 36 +++
 rtl/fib_step_cnt.sv | 35 +++
 rtl/fib_ctrl.sv | 126 ++++++++++++
 tb/tb_fib_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci control slice: widths, the state
// encoding and the datapath word type. The state register is one-hot.
// The enum values are bit positions in that vector, not encoded states.
package fib_pkg;

   localparam int FIB_W     = 20;   // datapath width, matches calc
   localparam int FIB_NW    = 5;    // width of the term index n
   localparam int FIB_N_MAX = 30;   // F(30)=832040 is the last term that fits

   // Bit positions inside the one-hot state vector.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_INIT  = 3'd2,
      ST_STEP  = 3'd3,
      ST_DONE  = 3'd4
   } state_idx_e;

   localparam int ST_NUM = 5;

   typedef logic [ST_NUM-1:0] state_t;

   // Reset and illegal-state recovery value: only the IDLE bit set.
   localparam state_t ST_RESET = 5'b00001;

   typedef logic [FIB_W-1:0] fib_t;

   // Build a one-hot state vector from a state bit position.
   function automatic state_t onehot(input state_idx_e s);
      state_t v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fib_step_cnt.sv
// Loadable down-counter that sets the number of STEP cycles.
// Latency: the load and decrement results are visible in the next cycle. The
// last flag is combinational from the count register.
// Backpressure: none. The count holds while dec is low and does not go below zero.
// Ports: clk/rst (async, active-high), load + load_val, dec, last (count==1).
module fib_step_cnt
   import fib_pkg::*;
#(
   parameter int NW = FIB_NW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [NW-1:0] load_val,
   input  logic          dec,
   output logic          last
);

   logic [NW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - NW'(1);
      end
   end

   // The controller leaves STEP in the cycle this flag is high, so it sees
   // exactly load_val STEP cycles.
   assign last = (count == NW'(1));

endmodule

// File: rtl/fib_ctrl.sv
// Control FSM for the calc Fibonacci datapath. It sequences rst_ctl/en/mux and
// captures F(n).
// Latency: done in cycle 3 for n=0, cycle 4+max(n-2,0) for n>=1, and cycle 1
// when n is rejected.
// Backpressure: ready is high only in IDLE. A start at any other time is
// dropped, not queued.
// Ports: clk, rst (async, active-high); request start/n/ready; completion
// done/err/fib_out; datapath result_in (from calc) and rst_ctl/en/mux (to calc).
module fib_ctrl
   import fib_pkg::*;
#(
   parameter int W     = FIB_W,
   parameter int NW    = FIB_NW,
   parameter int N_MAX = FIB_N_MAX
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [NW-1:0] n,
   output logic          ready,
   output logic          done,
   output logic          err,
   output logic [W-1:0]  fib_out,
   input  logic [W-1:0]  result_in,
   output logic          rst_ctl,
   output logic          en,
   output logic          mux
);

   state_t        state_q;
   state_t        state_d;
   logic [NW-1:0] n_q;
   logic [NW-1:0] cnt_load_val;
   logic          n_bad;
   logic          accept;
   logic          reject;
   logic          cnt_last;

   // Request decode. An out-of-range n is answered from IDLE and never
   // touches the datapath.
   assign n_bad  = (n > NW'(N_MAX));
   assign accept = state_q[ST_IDLE] & start & ~n_bad;
   assign reject = state_q[ST_IDLE] & start &  n_bad;

   // Number of STEP cycles is max(n-2,0). INIT alone already yields F(1)=F(2)=1.
   assign cnt_load_val = (n >= NW'(2)) ? (n - NW'(2)) : '0;

   fib_step_cnt #(
      .NW       (NW)
   ) u_step_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (cnt_load_val),
      .dec      (state_q[ST_STEP]),
      .last     (cnt_last)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (state_q[ST_IDLE]) begin
         if (accept) begin
            state_d = onehot(ST_CLEAR);
         end
      end else if (state_q[ST_CLEAR]) begin
         // F(0)=0 is what the cleared datapath already presents.
         state_d = (n_q == '0) ? onehot(ST_DONE) : onehot(ST_INIT);
      end else if (state_q[ST_INIT]) begin
         state_d = (n_q >= NW'(3)) ? onehot(ST_STEP) : onehot(ST_DONE);
      end else if (state_q[ST_STEP]) begin
         if (cnt_last) begin
            state_d = onehot(ST_DONE);
         end
      end else if (state_q[ST_DONE]) begin
         state_d = onehot(ST_IDLE);
      end else begin
         // Any non-one-hot value (upset) goes back to a clean IDLE.
         state_d = ST_RESET;
      end
   end

   // Outputs are taken straight from state flops, with no decode between the
   // flops and the datapath. rst_ctl drives an asynchronous clear in calc, so it
   // must be exactly the CLEAR flop.
   always_comb begin
      ready   = state_q[ST_IDLE];
      rst_ctl = state_q[ST_CLEAR];
      en      = state_q[ST_INIT] | state_q[ST_STEP];
      mux     = state_q[ST_INIT];
   end

   // Request latch, result capture and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q     <= '0;
         err     <= 1'b0;
         fib_out <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            n_q <= n;
            err <= 1'b0;
         end else if (reject) begin
            // fib_out keeps the last good result.
            err  <= 1'b1;
            done <= 1'b1;
         end
         if (state_q[ST_DONE]) begin
            fib_out <= result_in;
            done    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fib_ctrl.sv
// Directed bench for fib_ctrl with a behavioural calc datapath attached.
// Latency: checks done-cycle numbers against hand-computed L values.
// Backpressure: exercises ignored starts and a start issued in the done cycle.
module tb_fib_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  n;
   logic        ready;
   logic        done;
   logic        err;
   logic [19:0] fib_out;
   logic [19:0] result_in;
   logic        rst_ctl;
   logic        en;
   logic        mux;

   logic [19:0] fn1;
   logic [19:0] fn2;

   int tests  = 0;
   int failed = 0;

   int cyc;
   int rc;
   int ec;
   int mc;

   always #5 clk = ~clk;

   fib_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n         (n),
      .ready     (ready),
      .done      (done),
      .err       (err),
      .fib_out   (fib_out),
      .result_in (result_in),
      .rst_ctl   (rst_ctl),
      .en        (en),
      .mux       (mux)
   );

   // Behavioural calc datapath: Fn1/Fn2 registers with async clear.
   always_ff @(posedge clk or posedge rst or posedge rst_ctl) begin
      if (rst || rst_ctl) begin
         fn1 <= '0;
         fn2 <= '0;
      end else if (en) begin
         if (mux) begin
            fn1 <= 20'd1;
            fn2 <= 20'd0;
         end else begin
            fn1 <= fn1 + fn2;
            fn2 <= fn1;
         end
      end
   end
   assign result_in = fn1 + fn2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive start for one cycle. The caller is 1 time unit after a posedge, in
   // cycle 0. The task returns in cycle 1.
   task automatic send(input logic [4:0] nv);
      start = 1'b1;
      n     = nv;
      tick();
      start = 1'b0;
   endtask

   // Count datapath controls from cycle c0 until done, with a bounded wait.
   task automatic wait_done(input int c0, output int c, output int r, output int e, output int m);
      c = c0; r = 0; e = 0; m = 0;
      while (1) begin
         r += int'(rst_ctl);
         e += int'(en);
         m += int'(mux);
         if (done || c >= 200) break;
         tick();
         c++;
      end
   endtask

   // Full request: returns with the bench in the done cycle.
   task automatic req(input logic [4:0] nv, input int exp_l, input int exp_f,
                      input int exp_en, input int exp_mux, input string tag);
      send(nv);
      wait_done(1, cyc, rc, ec, mc);
      chk({tag, "_latency"}, cyc, exp_l);
      chk({tag, "_fib"},     32'(fib_out), exp_f);
      chk({tag, "_err"},     32'(err), 0);
      chk({tag, "_ready"},   32'(ready), 1);
      chk({tag, "_rstctl"},  rc, 1);
      chk({tag, "_en"},      ec, exp_en);
      chk({tag, "_mux"},     mc, exp_mux);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b1;
      n     = 5'd5;
      #2 rst = 1'b1;

      // Reset held with start asserted: nothing may move.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ready",   32'(ready),   1);
         chk("rst_done",    32'(done),    0);
         chk("rst_err",     32'(err),     0);
         chk("rst_fib",     32'(fib_out), 0);
         chk("rst_rstctl",  32'(rst_ctl), 0);
         chk("rst_en",      32'(en),      0);
         chk("rst_mux",     32'(mux),     0);
      end
      start = 1'b0;
      rst   = 1'b0;
      tick();

      // Small terms. The order makes each fib_out change.
      req(5'd3, 5, 2, 2, 1, "n3");
      tick();
      req(5'd0, 3, 0, 0, 0, "n0");
      tick();
      req(5'd1, 4, 1, 1, 1, "n1");
      tick();
      req(5'd2, 4, 1, 1, 1, "n2");
      tick();

      // Larger terms, including the largest legal index.
      req(5'd10, 12, 55,     9,  1, "n10");
      tick();
      req(5'd20, 22, 6765,   19, 1, "n20");
      tick();
      req(5'd30, 32, 832040, 29, 1, "n30");
      tick();

      // Out-of-range request: immediate done+err, no datapath activity.
      send(5'd31);
      wait_done(1, cyc, rc, ec, mc);
      chk("n31_latency", cyc, 1);
      chk("n31_err",     32'(err), 1);
      chk("n31_fib",     32'(fib_out), 832040);
      chk("n31_ready",   32'(ready), 1);
      chk("n31_rstctl",  rc, 0);
      chk("n31_en",      ec, 0);
      tick();
      req(5'd5, 7, 5, 4, 1, "n5");
      tick();

      // A start during STEP is ignored. A start in the done cycle is taken.
      send(5'd10);
      tick(); tick(); tick();          // cycle 4, in STEP
      start = 1'b1;
      n     = 5'd3;
      tick();                          // cycle 5
      start = 1'b0;
      wait_done(5, cyc, rc, ec, mc);
      chk("ign_latency", cyc, 12);
      chk("ign_fib",     32'(fib_out), 55);
      chk("ign_rstctl",  rc, 0);
      req(5'd7, 9, 13, 6, 1, "b2b_n7");
      tick();

      // Reset in the middle of STEP for n=25.
      send(5'd25);
      tick(); tick(); tick(); tick();  // cycle 5, in STEP
      chk("mid_en_before", 32'(en), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_ready", 32'(ready), 1);
      chk("mid_en",    32'(en),    0);
      chk("mid_fib",   32'(fib_out), 0);
      chk("mid_done",  32'(done),  0);
      tick();
      rst = 1'b0;
      rc = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         rc += int'(done) + int'(en);
      end
      chk("mid_quiet", rc, 0);
      req(5'd6, 8, 8, 5, 1, "n6");
      tick();
      chk("final_done_low", 32'(done), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
